// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin drain of four per-class FIFOs into one output FIFO.
// One-cycle ARB bubble per turn, then up to weight[cur] back-to-back pops.
module vc_wrr_scheduler #(
  parameter int DATA_W   = 12,
  parameter int WEIGHT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_load,
  input  logic [WEIGHT_W-1:0] cfg_weight0,
  input  logic [WEIGHT_W-1:0] cfg_weight1,
  input  logic [WEIGHT_W-1:0] cfg_weight2,
  input  logic [WEIGHT_W-1:0] cfg_weight3,
  input  logic                empty0,
  input  logic                empty1,
  input  logic                empty2,
  input  logic                empty3,
  input  logic [DATA_W-1:0]   data_in0,
  input  logic [DATA_W-1:0]   data_in1,
  input  logic [DATA_W-1:0]   data_in2,
  input  logic [DATA_W-1:0]   data_in3,
  input  logic                out_alm_full,
  output logic                pop0,
  output logic                pop1,
  output logic                pop2,
  output logic                pop3,
  output logic                push_out,
  output logic [DATA_W-1:0]   data_out,
  output logic [1:0]          grant,
  output logic                busy
);

  typedef enum logic {
    ARB   = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          cur_q, cur_d;
  logic [1:0]          last_q, last_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] wt_q [4];
  logic [WEIGHT_W-1:0] wt_d [4];
  logic                push_q, push_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          grant_q, grant_d;

  logic [WEIGHT_W-1:0] cfg_w [4];
  logic [DATA_W-1:0]   din [4];
  logic [3:0]          empty_v;
  logic                any_req;
  logic [1:0]          sel;
  logic                sel_found;
  logic                p;

  assign cfg_w[0] = cfg_weight0;
  assign cfg_w[1] = cfg_weight1;
  assign cfg_w[2] = cfg_weight2;
  assign cfg_w[3] = cfg_weight3;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  assign empty_v = {empty3, empty2, empty1, empty0};
  assign any_req = ~&empty_v;

  // Rotating search starting just after the last served class.
  always_comb begin
    logic [1:0] idx;
    sel       = last_q;
    sel_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + k[1:0];
      if (!sel_found && !empty_v[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  assign p = (state_q == SERVE) & enable & ~out_alm_full
           & ~empty_v[cur_q] & ~reset;

  assign pop0 = p & (cur_q == 2'd0);
  assign pop1 = p & (cur_q == 2'd1);
  assign pop2 = p & (cur_q == 2'd2);
  assign pop3 = p & (cur_q == 2'd3);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    credit_d = credit_q;
    push_d   = 1'b0;
    data_d   = data_q;
    grant_d  = grant_q;
    for (int i = 0; i < 4; i++) begin
      wt_d[i] = wt_q[i];
      if (cfg_load) begin
        wt_d[i] = (cfg_w[i] == '0) ? WEIGHT_W'(1) : cfg_w[i];
      end
    end
    case (state_q)
      ARB: begin
        if (enable && any_req) begin
          state_d  = SERVE;
          cur_d    = sel;
          credit_d = wt_q[sel];
        end
      end
      SERVE: begin
        if (p) begin
          credit_d = credit_q - WEIGHT_W'(1);
          push_d   = 1'b1;
          data_d   = din[cur_q];
          grant_d  = cur_q;
          if (credit_q == WEIGHT_W'(1)) begin
            state_d  = ARB;
            last_d   = cur_q;
            credit_d = '0;
          end
        end else if (empty_v[cur_q]) begin
          state_d  = ARB;
          last_d   = cur_q;
          credit_d = '0;
        end
      end
    endcase
  end

  // last=3 on reset so the first search begins at class 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      cur_q    <= 2'd0;
      last_q   <= 2'd3;
      credit_q <= '0;
      push_q   <= 1'b0;
      data_q   <= '0;
      grant_q  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        wt_q[i] <= WEIGHT_W'(1);
      end
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      push_q   <= push_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      for (int i = 0; i < 4; i++) begin
        wt_q[i] <= wt_d[i];
      end
    end
  end

  assign push_out = push_q;
  assign data_out = data_q;
  assign grant    = grant_q;
  assign busy     = (state_q == SERVE);

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Bench for vc_wrr_scheduler: hand sequences, table of drain orders,
// and random runs against a turn-level model of the weighted rotation.
module tb_vc_wrr_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, cfg_load, alm;
  logic [2:0]  cw [4];
  logic [3:0]  empty;
  logic [11:0] din [4];
  wire  [3:0]  pop;
  wire         push_out;
  wire  [11:0] data_out;
  wire  [1:0]  grant;
  wire         busy;

  vc_wrr_scheduler #(.DATA_W(12), .WEIGHT_W(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
    .cfg_weight0(cw[0]), .cfg_weight1(cw[1]),
    .cfg_weight2(cw[2]), .cfg_weight3(cw[3]),
    .empty0(empty[0]), .empty1(empty[1]),
    .empty2(empty[2]), .empty3(empty[3]),
    .data_in0(din[0]), .data_in1(din[1]),
    .data_in2(din[2]), .data_in3(din[3]),
    .out_alm_full(alm),
    .pop0(pop[0]), .pop1(pop[1]), .pop2(pop[2]), .pop3(pop[3]),
    .push_out(push_out), .data_out(data_out),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  g;
    logic [11:0] d;
  } ev_t;

  typedef struct {
    int w [4];
    int n [4];
    int len;
    int g [16];
  } vec_t;

  logic [11:0] fq [4][$];
  ev_t         obs [$];
  ev_t         expq [$];
  logic [3:0]  snap;
  logic        snap_push;
  int          total = 0;
  int          bad = 0;
  vec_t        vt [5];

  function automatic logic [11:0] word(input int c, input int s);
    return {c[1:0], 2'b00, s[7:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      empty[i] = (fq[i].size() == 0);
      din[i]   = empty[i] ? 12'h000 : fq[i][0];
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) fq[i].delete();
    obs.delete();
    refresh();
  endtask

  task automatic fill(input int c, input int n);
    for (int s = 0; s < n; s++) fq[c].push_back(word(c, s));
    refresh();
  endtask

  // One clock: snapshot pops mid-cycle, retire them at the edge.
  task automatic tick();
    logic ok;
    refresh();
    #1;
    snap      = pop;
    snap_push = push_out;
    ok = ($countones(snap) <= 1) && ((snap & empty) == 4'b0000)
      && (snap == 4'b0000 || (enable && !alm && !reset));
    check("pop_legal", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (snap[i]) void'(fq[i].pop_front());
    end
    refresh();
    check("push_latency", {31'd0, push_out}, {31'd0, |snap});
    if (push_out === 1'b1) obs.push_back('{grant, data_out});
    @(negedge clk);
  endtask

  task automatic do_reset();
    enable   = 1'b0;
    alm      = 1'b0;
    cfg_load = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_w(input int a, input int b, input int c, input int d);
    cw[0] = 3'(a); cw[1] = 3'(b); cw[2] = 3'(c); cw[3] = 3'(d);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  function automatic bit all_empty();
    return fq[0].size() == 0 && fq[1].size() == 0
        && fq[2].size() == 0 && fq[3].size() == 0;
  endfunction

  task automatic drain(input int bound);
    int cyc = 0;
    while (!(all_empty() && busy === 1'b0) && cyc < bound) begin
      tick();
      cyc++;
    end
    check("drain_timeout", {31'd0, all_empty()}, 32'd1);
    tick();
    tick();
  endtask

  // Turn-level model: each turn the next non-empty class after the
  // previous one sends min(weight, remaining) words.
  task automatic build_exp(input int w [4], input int n [4]);
    int rem [4];
    int last, c, take, left;
    expq.delete();
    last = 3;
    left = 0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = n[i];
      left  += n[i];
    end
    while (left > 0) begin
      c = -1;
      for (int k = 1; k <= 4; k++) begin
        if (c < 0 && rem[(last + k) % 4] > 0) c = (last + k) % 4;
      end
      take = (w[c] == 0) ? 1 : w[c];
      if (take > rem[c]) take = rem[c];
      for (int j = 0; j < take; j++) begin
        expq.push_back('{2'(c), word(c, n[c] - rem[c])});
        rem[c]--;
        left--;
      end
      last = c;
    end
  endtask

  int pat [10];

  initial begin
    vt[0] = '{w:'{2,1,0,0}, n:'{6,6,0,0}, len:12,
              g:'{0,0,1,0,0,1,0,0,1,1,1,1,0,0,0,0}};
    vt[1] = '{w:'{0,0,0,0}, n:'{1,2,1,2}, len:6,
              g:'{0,1,2,3,1,3,0,0,0,0,0,0,0,0,0,0}};
    vt[2] = '{w:'{3,0,2,7}, n:'{0,0,3,2}, len:5,
              g:'{2,2,3,3,2,0,0,0,0,0,0,0,0,0,0,0}};
    vt[3] = '{w:'{1,1,1,7}, n:'{2,0,0,2}, len:4,
              g:'{0,3,3,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    vt[4] = '{w:'{4,2,1,3}, n:'{5,3,2,4}, len:14,
              g:'{0,0,0,0,1,1,2,3,3,3,0,1,2,3,0,0}};

    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; alm = 1'b0;
    for (int i = 0; i < 4; i++) cw[i] = 3'd0;
    flush();
    @(negedge clk);

    // Reset with every FIFO non-empty
    for (int c = 0; c < 4; c++) fill(c, 2);
    tick();
    enable = 1'b1;
    tick();
    check("rst_pops", {28'd0, snap}, 32'd0);
    check("rst_push", {31'd0, push_out}, 32'd0);
    check("rst_data", {20'd0, data_out}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    check("idle_no_pop", {28'd0, snap}, 32'd0);
    enable = 1'b1;
    tick();
    check("arb_bubble", {28'd0, snap}, 32'd0);
    check("busy_serve", {31'd0, busy}, 32'd1);
    tick();
    check("first_pop", {28'd0, snap}, 32'd1);
    check("first_push", {31'd0, push_out}, 32'd1);
    check("first_data", {20'd0, data_out}, {20'd0, word(0, 0)});
    check("first_grant", {30'd0, grant}, 32'd0);

    // Weight 0 on class 2 behaves as weight 1
    flush();
    do_reset();
    load_w(1, 1, 0, 1);
    fill(2, 3);
    enable = 1'b1;
    pat = '{0,1,0,1,0,1,0,0,0,0};
    for (int c = 0; c < 8; c++) begin
      tick();
      check("w0_pattern", {31'd0, snap[2]}, 32'(pat[c]));
    end
    check("w0_idle_push", {31'd0, push_out}, 32'd0);
    check("w0_idle_busy", {31'd0, busy}, 32'd0);

    // Almost-full pulse in a weight-4 burst
    flush();
    do_reset();
    load_w(4, 1, 1, 1);
    fill(0, 8);
    enable = 1'b1;
    pat = '{0,1,1,0,0,0,1,1,0,1};
    for (int c = 0; c < 10; c++) begin
      alm = (c >= 3 && c <= 5);
      tick();
      check("af_pop", {31'd0, snap[0]}, 32'(pat[c]));
      if (c == 3) check("af_trailing", {31'd0, snap_push}, 32'd1);
      if (c == 4 || c == 5 || c == 6)
        check("af_no_push", {31'd0, snap_push}, 32'd0);
    end
    alm = 1'b0;
    check("af_words_left", fq[0].size(), 32'd3);

    // Reset mid-burst, with a coincident cfg_load that must lose
    flush();
    do_reset();
    load_w(3, 1, 1, 1);
    fill(0, 4);
    fill(1, 4);
    enable = 1'b1;
    tick();
    tick();
    check("mid_pop", {28'd0, snap}, 32'd1);
    reset    = 1'b1;
    cfg_load = 1'b1;
    cw[0] = 3'd7; cw[1] = 3'd7; cw[2] = 3'd7; cw[3] = 3'd7;
    tick();
    check("mid_rst_pop", {28'd0, snap}, 32'd0);
    check("mid_rst_push", {31'd0, push_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset    = 1'b0;
    cfg_load = 1'b0;
    obs.delete();
    for (int c = 0; c < 6; c++) tick();
    check("mid_count", obs.size(), 32'd3);
    if (obs.size() == 3) begin
      check("mid_d0", {20'd0, obs[0].d}, {20'd0, word(0, 1)});
      check("mid_d1", {20'd0, obs[1].d}, {20'd0, word(1, 0)});
      check("mid_d2", {20'd0, obs[2].d}, {20'd0, word(0, 2)});
    end

    // Table of full drains with hand-derived grant orders
    for (int t = 0; t < 5; t++) begin
      flush();
      do_reset();
      load_w(vt[t].w[0], vt[t].w[1], vt[t].w[2], vt[t].w[3]);
      for (int c = 0; c < 4; c++) fill(c, vt[t].n[c]);
      obs.delete();
      enable = 1'b1;
      drain(200);
      enable = 1'b0;
      check("tab_len", obs.size(), 32'(vt[t].len));
      for (int j = 0; j < vt[t].len; j++) begin
        if (j < obs.size())
          check("tab_grant", {30'd0, obs[j].g}, 32'(vt[t].g[j]));
        else
          check("tab_grant", 32'hDEAD, 32'(vt[t].g[j]));
      end
    end

    // Random weights, depths and stalls against the turn model
    for (int it = 0; it < 12; it++) begin
      int w [4];
      int n [4];
      int cyc;
      flush();
      do_reset();
      for (int c = 0; c < 4; c++) begin
        w[c] = $urandom_range(0, 7);
        n[c] = $urandom_range(0, 6);
      end
      load_w(w[0], w[1], w[2], w[3]);
      for (int c = 0; c < 4; c++) fill(c, n[c]);
      build_exp(w, n);
      obs.delete();
      cyc = 0;
      while (!(all_empty() && busy === 1'b0) && cyc < 1000) begin
        enable = ($urandom_range(0, 3) != 0);
        alm    = ($urandom_range(0, 3) == 0);
        tick();
        cyc++;
      end
      enable = 1'b1;
      alm    = 1'b0;
      tick();
      tick();
      check("rnd_drain", {31'd0, all_empty()}, 32'd1);
      check("rnd_len", obs.size(), expq.size());
      for (int j = 0; j < expq.size(); j++) begin
        if (j < obs.size()) begin
          check("rnd_grant", {30'd0, obs[j].g}, {30'd0, expq[j].g});
          check("rnd_data", {20'd0, obs[j].d}, {20'd0, expq[j].d});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_wrr_scheduler.md
Name: vc_wrr_scheduler

Overview:
- Weighted round-robin scheduler that drains the four per-class input FIFOs into the single shared output FIFO.
- Generates per-FIFO pop strobes and the output push strobe, and registers the selected 12-bit word.
- Stalls on output almost-full and on the global enable derived from the state machine's ACTIVE state.
- Per-class weights are loaded from configuration inputs and set how many consecutive words each class may send per turn.

Parameters:
- DATA_W, 12, word width (class/dest fields live inside the word; the block does not interpret them).
- WEIGHT_W, 3, width of each weight and of the credit counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  high = scheduling allowed (FSM in ACTIVE).
- cfg_load  input  1  capture cfg_weight0..3 on this edge.
- cfg_weight0..cfg_weight3  input  WEIGHT_W each  class weights; 0 is stored as 1.
- empty0..empty3  input  1 each  input FIFO empty flags.
- data_in0..data_in3  input  DATA_W each  head word of each input FIFO (show-ahead; valid while emptyN=0).
- out_alm_full  input  1  shared output FIFO almost-full.
- pop0..pop3  output  1 each  combinational pop strobes to the input FIFOs.
- push_out  output  1  registered push to the output FIFO.
- data_out  output  DATA_W  registered word to the output FIFO.
- grant  output  2  index of the class that supplied the current data_out.
- busy  output  1  high while in SERVE.

Behaviour:
- Reset values (synchronous, clk edge with reset=1):
  - state=ARB, cur=0, last=3, credit=0, all weights=1.
  - push_out=0, data_out=0, grant=0, busy=0.
  - pops are 0 combinationally while reset is high.
- cfg_load:
  - Weights are captured in any state; a zero weight is stored as 1.
  - New weights take effect at the next credit reload; the credit of the class currently in SERVE is unchanged.
  - cfg_load coincident with reset: reset wins.
- ARB state (one-cycle arbitration bubble, never pops):
  - Runs only if enable=1 and at least one emptyN=0.
  - Search order is last+1, last+2, last+3, last (mod 4); the first non-empty class becomes sel.
  - Next state is SERVE with cur=sel and credit=weight[sel].
  - Otherwise it stays in ARB.
- SERVE state:
  - Pop condition: p = enable & ~out_alm_full & ~empty[cur].
  - popN = p & (cur==N); at most one pop asserts per cycle, and never to an empty FIFO.
  - On p: credit decrements; data_out <= data_in[cur], grant <= cur and push_out <= 1 on the same edge (output latency 1 cycle from pop).
  - Without p: push_out <= 0; data_out and grant hold.
  - p with credit==1: go to ARB, last <= cur, credit <= 0.
  - empty[cur]=1 (class drained early): go to ARB, last <= cur, credit cleared, no pop.
  - enable=0 or out_alm_full=1 with empty[cur]=0: stay in SERVE, credit held, no pop.
- Throughput:
  - A class with weight W sends W words back-to-back, followed by one ARB bubble.
  - A single non-empty class is re-granted after each bubble.
- Backpressure: at most one push reaches the output FIFO after out_alm_full rises (the word popped on the preceding edge). The output FIFO threshold provides at least 1 slot of slack.
- busy = (state==SERVE), registered.
- Reset mid-operation:
  - An in-flight word is dropped: push_out is 0 after the reset edge.
  - Input FIFO contents are untouched.
  - Scheduling restarts from class 0.

Test Plan:
- Reset with all FIFOs non-empty and enable=0 -> all outputs 0, pops 0; raise enable -> ARB 1 cycle, then pop0 in the next cycle, push_out=1 with data_out=FIFO0 head one cycle later.
- Weights {2,1,0,0}, FIFO0 and FIFO1 each holding 6 words, enable=1 -> grant sequence 0,0,(bubble),1,(bubble),0,0,(bubble),1…; FIFO0 ends empty after 9 pushes total.
- Weight 0 on class 2 with only FIFO2 non-empty (3 words) -> stored weight 1; pattern pop, bubble, pop, bubble, pop, then ARB idle with push_out=0.
- out_alm_full pulsed high for 3 cycles mid-burst with weight 4 -> pops stop the same cycle, exactly 1 trailing push, credit resumes at the held value, 4 words total in the burst.
- FIFO3 (weight 7) goes empty after 2 words -> transition to ARB, last=3, next grant goes to the lowest-index non-empty class after 3 (i.e. 0 if non-empty).
- reset asserted during a weight-3 burst after the first pop -> push_out=0 and weights=1 after the edge; the next grant is class 0 if it is non-empty.
